// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty execution controller.
// Holds field positions, format codes and the FSM encoding.
package bitty_pkg;

    localparam int NREGS   = 8;
    localparam int INSTR_W = 16;
    localparam int REG_W   = 3;
    localparam int OP_W    = 3;
    localparam int FMT_W   = 2;

    localparam int RX_LSB  = 13;
    localparam int RY_LSB  = 10;
    localparam int OP_LSB  = 2;
    localparam int FMT_LSB = 0;

    localparam logic [FMT_W-1:0] FMT_R = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_S,
        EXEC,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/bitty_decode.sv
// Combinational field extraction for one instruction word.
// Bits [9:5] carry nothing this controller uses.
module bitty_decode
    import bitty_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic [REG_W-1:0]   rx,
    output logic [REG_W-1:0]   ry,
    output logic [OP_W-1:0]    op,
    output logic [FMT_W-1:0]   fmt
);

    logic unused_bits;

    assign rx  = instr[RX_LSB  +: REG_W];
    assign ry  = instr[RY_LSB  +: REG_W];
    assign op  = instr[OP_LSB  +: OP_W];
    assign fmt = instr[FMT_LSB +: FMT_W];

    assign unused_bits = ^instr[9:5];

endmodule

// File: rtl/bitty_exec_ctrl.sv
// Multi-cycle execute controller: IDLE, LOAD_S, EXEC, WRITE, DONE.
// One instruction in flight; hold freezes state and gates enables.
module bitty_exec_ctrl #(
    parameter int NREGS     = bitty_pkg::NREGS,
    parameter int ALU_SEL_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_valid,
    input  logic [15:0]          instr,
    input  logic                 hold,
    output logic                 instr_ready,
    output logic                 inst_en,
    output logic [2:0]           mux_sel,
    output logic                 s_en,
    output logic                 c_en,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic [NREGS-1:0]     reg_en,
    output logic                 done,
    output logic                 illegal,
    output logic                 busy
);

    import bitty_pkg::*;

    state_t state_q;
    state_t state_d;

    logic [INSTR_W-1:0] instr_q;
    logic               ill_q;
    logic               hs;
    logic               go;

    logic [FMT_W-1:0] in_fmt;
    logic [REG_W-1:0] unused_in_rx;
    logic [REG_W-1:0] unused_in_ry;
    logic [OP_W-1:0]  unused_in_op;

    logic [REG_W-1:0] q_rx;
    logic [REG_W-1:0] q_ry;
    logic [OP_W-1:0]  q_op;
    logic [FMT_W-1:0] unused_q_fmt;

    bitty_decode u_dec_in (
        .instr (instr),
        .rx    (unused_in_rx),
        .ry    (unused_in_ry),
        .op    (unused_in_op),
        .fmt   (in_fmt)
    );

    bitty_decode u_dec_q (
        .instr (instr_q),
        .rx    (q_rx),
        .ry    (q_ry),
        .op    (q_op),
        .fmt   (unused_q_fmt)
    );

    assign instr_ready = reset && !hold && (state_q == IDLE);
    assign hs          = instr_ready && instr_valid;
    assign go          = reset && !hold;
    assign busy        = (state_q != IDLE);

    // State register; hold freezes the current state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else if (!hold) begin
            state_q <= state_d;
        end
    end

    // Captured instruction and pending-illegal flag, loaded on handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= '0;
            ill_q   <= 1'b0;
        end else if (hs) begin
            instr_q <= instr;
            ill_q   <= (in_fmt != FMT_R);
        end
    end

    // Next-state and datapath controls for the current state.
    always_comb begin
        state_d = state_q;
        inst_en = hs;
        mux_sel = '0;
        s_en    = 1'b0;
        c_en    = 1'b0;
        alu_sel = '0;
        reg_en  = '0;
        done    = 1'b0;
        illegal = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    state_d = (in_fmt == FMT_R) ? LOAD_S : DONE;
                end
            end
            LOAD_S: begin
                state_d = EXEC;
                mux_sel = q_rx;
                s_en    = go;
            end
            EXEC: begin
                state_d = WRITE;
                mux_sel = q_ry;
                alu_sel = ALU_SEL_W'(q_op);
                c_en    = go;
            end
            WRITE: begin
                state_d = DONE;
                if (go) begin
                    reg_en = NREGS'(1) << q_rx;
                end
            end
            DONE: begin
                state_d = IDLE;
                done    = go;
                illegal = go && ill_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bitty_exec_ctrl.sv
// Scoreboard bench for bitty_exec_ctrl.
// Driver pushes expectations at handshake; monitor pops on done.
module tb_bitty_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        hold;
    logic        instr_ready;
    logic        inst_en;
    logic [2:0]  mux_sel;
    logic        s_en;
    logic        c_en;
    logic [2:0]  alu_sel;
    logic [7:0]  reg_en;
    logic        done;
    logic        illegal;
    logic        busy;

    typedef struct {
        logic [2:0] rx;
        logic [2:0] ry;
        logic [2:0] op;
        bit         ill;
        int         hs;
        int         extra;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   last_hs = 0;

    bitty_exec_ctrl #(.NREGS(8), .ALU_SEL_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .hold        (hold),
        .instr_ready (instr_ready),
        .inst_en     (inst_en),
        .mux_sel     (mux_sel),
        .s_en        (s_en),
        .c_en        (c_en),
        .alu_sel     (alu_sel),
        .reg_en      (reg_en),
        .done        (done),
        .illegal     (illegal),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: samples mid-cycle and checks against the queue head.
    initial begin
        exp_t e;
        int s_n;
        int c_n;
        int w_n;
        s_n = 0;
        c_n = 0;
        w_n = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                chk("reset_outs", {instr_ready, inst_en, s_en, c_en, done,
                                   illegal, busy, mux_sel, alu_sel, reg_en}, 0);
                s_n = 0;
                c_n = 0;
                w_n = 0;
            end else begin
                if (hold)
                    chk("hold_quiet", {instr_ready, inst_en, s_en, c_en, done, reg_en}, 0);
                if (illegal && !done)
                    chk("illegal_without_done", illegal, 0);
                assert (reg_en == 0 || $onehot(reg_en))
                else $error("FAIL reg_en_onehot: got %b", reg_en);
                if (sb.size() == 0) begin
                    chk("idle_quiet", {inst_en, s_en, c_en, done, reg_en}, 0);
                end else begin
                    e = sb[0];
                    if (inst_en) chk("hs_cycle", cyc, sb[$].hs);
                    if (s_en) begin
                        s_n++;
                        chk("s_cycle", cyc, e.hs + 1);
                        chk("s_mux", mux_sel, e.rx);
                    end
                    if (c_en) begin
                        c_n++;
                        chk("c_cycle", cyc, e.hs + 2 + e.extra);
                        chk("c_mux", mux_sel, e.ry);
                        chk("c_alu", alu_sel, e.op);
                    end
                    if (reg_en != 0) begin
                        w_n++;
                        chk("w_cycle", cyc, e.hs + 3 + e.extra);
                        chk("w_reg_en", reg_en, 8'(1) << e.rx);
                        chk("w_onehot", $onehot(reg_en), 1);
                    end
                    if (done) begin
                        chk("d_cycle", cyc, e.ill ? e.hs + 1 : e.hs + 4 + e.extra);
                        chk("d_illegal", illegal, e.ill);
                        chk("d_s_count", s_n, e.ill ? 0 : 1);
                        chk("d_c_count", c_n, e.ill ? 0 : 1);
                        chk("d_w_count", w_n, e.ill ? 0 : 1);
                        s_n = 0;
                        c_n = 0;
                        w_n = 0;
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    // Present one instruction; call just after a rising edge.
    task automatic issue(input logic [15:0] w, input logic [2:0] rx,
                         input logic [2:0] ry, input logic [2:0] op,
                         input bit ill, input int extra, input bit keep);
        exp_t e;
        int tries;
        tries = 0;
        instr = w;
        instr_valid = 1'b1;
        #1;
        while (!instr_ready && tries < 30) begin
            @(posedge clk);
            #2;
            tries++;
        end
        if (!instr_ready) begin
            chk("hs_timeout", instr_ready, 1);
            instr_valid = 1'b0;
            return;
        end
        e = '{rx, ry, op, ill, cyc, extra};
        sb.push_back(e);
        last_hs = cyc;
        @(posedge clk);
        #1;
        if (!keep) instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] w;
        logic [2:0]  r;
        logic [15:0] bad [3];
        int prev;
        int rel;

        reset = 1'b0;
        instr_valid = 1'b0;
        hold = 1'b0;
        instr = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Basic legal instruction, rx == ry.
        issue(16'h2408, 3'd1, 3'd1, 3'd2, 1'b0, 0, 1'b0);
        wait_idle();

        // Illegal formats.
        bad[0] = 16'hE001;
        bad[1] = 16'h0002;
        bad[2] = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            w = bad[i];
            issue(w, w[15:13], w[12:10], w[4:2], 1'b1, 0, 1'b0);
            wait_idle();
        end

        // Hold for three cycles while in EXEC.
        issue(16'h2408, 3'd1, 3'd1, 3'd2, 1'b0, 3, 1'b0);
        @(posedge clk);
        #1;
        hold = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #3;
            chk("hold_mux", mux_sel, 1);
            chk("hold_alu", alu_sel, 2);
            chk("hold_busy", busy, 1);
            @(posedge clk);
            #1;
        end
        hold = 1'b0;
        wait_idle();

        // Hold in IDLE blocks the handshake.
        hold = 1'b1;
        instr = 16'h4C14;
        instr_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        hold = 1'b0;
        issue(16'h4C14, 3'd2, 3'd3, 3'd5, 1'b0, 0, 1'b0);
        wait_idle();

        // Back-to-back with valid held high.
        issue(16'h2408, 3'd1, 3'd1, 3'd2, 1'b0, 0, 1'b1);
        prev = last_hs;
        issue(16'h4C14, 3'd2, 3'd3, 3'd5, 1'b0, 0, 1'b0);
        chk("b2b_gap", last_hs - prev, 5);
        wait_idle();

        // Every writeback index, including register 0.
        for (int i = 0; i < 8; i++) begin
            r = 3'(i);
            w = {r, 3'(7 - i), 5'b00000, r, 2'b00};
            issue(w, r, 3'(7 - i), r, 1'b0, 0, 1'b0);
            wait_idle();
        end

        // Reset during WRITE abandons the instruction.
        issue(16'hA80C, 3'd5, 3'd2, 3'd3, 1'b0, 0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        #3;
        reset = 1'b0;
        sb.delete();
        #1;
        chk("rst_reg_en", reg_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", instr_ready, 0);
        chk("rst_done", done, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        rel = cyc;
        issue(16'h2408, 3'd1, 3'd1, 3'd2, 1'b0, 0, 1'b0);
        chk("first_edge_hs", last_hs, rel);
        wait_idle();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
